// File: rtl/isa_pkg.sv
// Shared RV64 opcode constants, format enum and immediate limits.
// Used by the encoder and by the core's immediate decode.
package isa_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    typedef enum logic [2:0] {
        FMT_R,
        FMT_I,
        FMT_S,
        FMT_B,
        FMT_U,
        FMT_J,
        FMT_BAD
    } fmt_e;

    localparam logic signed [63:0] IMM_I_MIN = -64'sd2048;
    localparam logic signed [63:0] IMM_I_MAX = 64'sd2047;
    localparam logic signed [63:0] IMM_B_MIN = -64'sd4096;
    localparam logic signed [63:0] IMM_B_MAX = 64'sd4094;
    localparam logic signed [63:0] IMM_J_MIN = -64'sd1048576;
    localparam logic signed [63:0] IMM_J_MAX = 64'sd1048574;

    typedef struct packed {
        logic [31:0] insn;
        logic [63:0] addr;
        logic        err;
    } buf_entry_t;

    function automatic fmt_e fmt_of(input logic [6:0] op);
        fmt_e f;
        case (op)
            OP_R:                         f = FMT_R;
            OP_IMM, OP_LOAD, OP_SYSTEM:   f = FMT_I;
            OP_STORE:                     f = FMT_S;
            OP_BRANCH, OP_JALR:           f = FMT_B;
            OP_LUI, OP_AUIPC:             f = FMT_U;
            OP_JAL:                       f = FMT_J;
            default:                      f = FMT_BAD;
        endcase
        return f;
    endfunction

    // Inverse of the encoder placement; JALR decodes as B here.
    function automatic logic [63:0] imm_decode(input logic [31:0] w);
        logic [63:0] v;
        case (fmt_of(w[6:0]))
            FMT_I:   v = {{52{w[31]}}, w[31:20]};
            FMT_S:   v = {{52{w[31]}}, w[31:25], w[11:7]};
            FMT_B:   v = {{51{w[31]}}, w[31], w[7], w[30:25],
                          w[11:8], 1'b0};
            FMT_U:   v = {{32{w[31]}}, w[31:12], 12'b0};
            FMT_J:   v = {{43{w[31]}}, w[31], w[19:12], w[20],
                          w[30:21], 1'b0};
            default: v = 64'b0;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/imm_packer.sv
// Classifies the opcode, places immediate bits into their word
// positions and flags immediates the format cannot represent.
module imm_packer
    import isa_pkg::*;
(
    input  logic [6:0]  opcode_i,
    input  logic [63:0] imm_i,
    output fmt_e        fmt_o,
    output logic [31:0] imm_bits_o,
    output logic        err_o
);

    logic signed [63:0] simm;
    logic               hi_sext;

    assign simm    = imm_i;
    assign hi_sext = (&imm_i[63:31]) | ~(|imm_i[63:31]);

    always_comb begin
        fmt_o      = fmt_of(opcode_i);
        imm_bits_o = 32'b0;
        err_o      = 1'b0;
        unique case (fmt_o)
            FMT_I: begin
                imm_bits_o[31:20] = imm_i[11:0];
                err_o = (simm < IMM_I_MIN) || (simm > IMM_I_MAX);
            end
            FMT_S: begin
                imm_bits_o[31:25] = imm_i[11:5];
                imm_bits_o[11:7]  = imm_i[4:0];
                err_o = (simm < IMM_I_MIN) || (simm > IMM_I_MAX);
            end
            FMT_B: begin
                imm_bits_o[31]    = imm_i[12];
                imm_bits_o[30:25] = imm_i[10:5];
                imm_bits_o[11:8]  = imm_i[4:1];
                imm_bits_o[7]     = imm_i[11];
                err_o = (simm < IMM_B_MIN) || (simm > IMM_B_MAX)
                      || imm_i[0];
            end
            FMT_U: begin
                imm_bits_o[31:12] = imm_i[31:12];
                err_o = (|imm_i[11:0]) || !hi_sext;
            end
            FMT_J: begin
                imm_bits_o[31]    = imm_i[20];
                imm_bits_o[30:21] = imm_i[10:1];
                imm_bits_o[20]    = imm_i[11];
                imm_bits_o[19:12] = imm_i[19:12];
                err_o = (simm < IMM_J_MIN) || (simm > IMM_J_MAX)
                      || imm_i[0];
            end
            FMT_BAD: begin
                err_o = 1'b1;
            end
            default: begin
                err_o = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/instruction_encoder.sv
// Packs decoded fields into RV64 words and streams them with
// sequential byte addresses through a 2-entry output buffer.
module instruction_encoder
    import isa_pkg::*;
#(
    parameter logic [63:0] BASE_ADDR = 64'h0,
    parameter int          ERR_CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [6:0]           opcode,
    input  logic [4:0]           rd,
    input  logic [4:0]           rs1,
    input  logic [4:0]           rs2,
    input  logic [2:0]           funct3,
    input  logic [6:0]           funct7,
    input  logic [63:0]          imm,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [31:0]          instruction,
    output logic [63:0]          addr,
    output logic                 err,
    output logic [ERR_CNT_W-1:0] err_count
);

    fmt_e        fmt;
    logic [31:0] imm_bits;
    logic        imm_err;
    logic [31:0] fields;
    buf_entry_t  entry;

    buf_entry_t           mem_q [2];
    logic                 head_q, head_d;
    logic                 tail_q, tail_d;
    logic [1:0]           cnt_q, cnt_d;
    logic [63:0]          addr_ctr_q, addr_ctr_d;
    logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic                 push, pop;

    imm_packer u_packer (
        .opcode_i   (opcode),
        .imm_i      (imm),
        .fmt_o      (fmt),
        .imm_bits_o (imm_bits),
        .err_o      (imm_err)
    );

    // Non-immediate fields; unknown opcodes fall back to R layout.
    always_comb begin
        fields = {funct7, rs2, rs1, funct3, rd, opcode};
        unique case (fmt)
            FMT_I: fields = {12'b0, rs1, funct3, rd, opcode};
            FMT_S,
            FMT_B: fields = {7'b0, rs2, rs1, funct3, 5'b0, opcode};
            FMT_U,
            FMT_J: fields = {20'b0, rd, opcode};
            default: fields = {funct7, rs2, rs1, funct3, rd, opcode};
        endcase
    end

    assign entry.insn = fields | imm_bits;
    assign entry.addr = addr_ctr_q;
    assign entry.err  = imm_err;

    assign in_ready  = (cnt_q != 2'd2);
    assign out_valid = (cnt_q != 2'd0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    always_comb begin
        head_d     = head_q;
        tail_d     = tail_q;
        cnt_d      = cnt_q;
        addr_ctr_d = addr_ctr_q;
        err_cnt_d  = err_cnt_q;
        if (push) begin
            tail_d     = ~tail_q;
            addr_ctr_d = addr_ctr_q + 64'd4;
            if (imm_err && !(&err_cnt_q)) begin
                err_cnt_d = err_cnt_q + 1'b1;
            end
        end
        if (pop) begin
            head_d = ~head_q;
        end
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + 2'd1;
            2'b01:   cnt_d = cnt_q - 2'd1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head_q     <= 1'b0;
            tail_q     <= 1'b0;
            cnt_q      <= 2'd0;
            addr_ctr_q <= BASE_ADDR;
            err_cnt_q  <= '0;
            mem_q[0]   <= '0;
            mem_q[1]   <= '0;
        end else begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            cnt_q      <= cnt_d;
            addr_ctr_q <= addr_ctr_d;
            err_cnt_q  <= err_cnt_d;
            if (push) begin
                mem_q[tail_q] <= entry;
            end
        end
    end

    assign instruction = mem_q[head_q].insn;
    assign addr        = mem_q[head_q].addr;
    assign err         = mem_q[head_q].err;
    assign err_count   = err_cnt_q;

endmodule

// File: doc/instruction_encoder.md
# instruction_encoder

Packs decoded instruction fields and a 64-bit signed immediate into a 32-bit RV64 instruction word. It is the inverse of the core's immediate decode. It validates that the immediate is representable in the opcode's format and assigns each word a sequential byte address. It feeds the instruction-memory loader and test-program generators through a valid/ready stream with a 2-entry output buffer.

## Interface
- BASE_ADDR, 64'h0, byte address assigned to the first accepted word after reset
- ERR_CNT_W, 16, width of saturating error counter
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- in_valid  in  1  field bundle valid
- in_ready  out  1  encoder can accept
- opcode  in  7  instruction[6:0]
- rd, rs1, rs2  in  5 each  register fields
- funct3  in  3;  funct7  in  7
- imm  in  64  signed immediate (byte offset for B/J, full value for U)
- out_valid  out  1  head word valid
- out_ready  in  1  consumer accepts head word
- instruction  out  32  encoded word
- addr  out  64  byte address of head word
- err  out  1  head word's immediate was not representable
- err_count  out  ERR_CNT_W  saturating count of accepted words with err

## Operation
- Format by opcode:
  - R = 0110011
  - I = 0010011, 0000011, 1110011
  - S = 0100011
  - B = 1100011, 1100111 (1100111 is B-format in this core; the encoder must match the decode)
  - U = 0110111, 0010111
  - J = 1101111
  - Any other opcode: pack as R, err=1.
- Bit placement:
  - R: funct7|rs2|rs1|funct3|rd|opcode.
  - I: imm[11:0]|rs1|funct3|rd|opcode.
  - S: imm[11:5]|rs2|rs1|funct3|imm[4:0]|opcode.
  - B: imm[12]|imm[10:5]|rs2|rs1|funct3|imm[4:1]|imm[11]|opcode.
  - U: imm[31:12]|rd|opcode.
  - J: imm[20]|imm[10:1]|imm[11]|imm[19:12]|rd|opcode.
- Range checks (err=1 on violation):
  - I/S: -2048..2047.
  - B: -4096..4094, imm[0]=0.
  - J: -2^20..2^20-2, imm[0]=0.
  - U: imm[11:0]=0 and imm[63:31] all equal.
  - R: imm ignored, never err.
- On err the word is still emitted, packed from the truncated bits. The stream never stalls on err.
- Accept = in_valid & in_ready.
- Each accept pushes {instruction, addr_ctr, err} into the buffer, then adds 4 to addr_ctr (mod 2^64).
- Each accept with err increments err_count, saturating at all-ones.
- Pop = out_valid & out_ready.
- in_ready = buffer count < 2. It depends on registered state only, never on out_ready.
- Simultaneous push and pop at count 1: count stays 1 and ordering is preserved.

## Timing
- Reset values:
  - Buffer empty, out_valid=0, instruction=0, addr=0, err=0, err_count=0.
  - addr_ctr=BASE_ADDR, in_ready=1.
- Inputs are ignored while reset is high.
- Latency 1: a word accepted at edge N shows out_valid=1 with its data after edge N.
- Outputs are fully registered; there is no combinational path from inputs to outputs.
- Full throughput (1 word/cycle) when out_ready is held high.
- Once asserted, out_valid and head data stay stable until popped.
- Reset mid-stream: buffered words are discarded and addr_ctr returns to BASE_ADDR on the same edge.

## Structure
- Shared package isa_pkg:
  - Opcode constants.
  - Format enum {FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J, FMT_BAD}.
  - Immediate min/max constants.
- The immediate decode should take opcode constants from the same package.
- Sub-module imm_packer (combinational): inputs {opcode, imm}; outputs {format, placed-imm bits, err}.
- Top level holds:
  - Field muxing.
  - 2-entry buffer (head/tail pointers + count).
  - addr_ctr and err_count.

## Test plan
- addi: opcode 0010011, rd=1, rs1=0, funct3=0, imm=-1 → instruction 32'hFFF00093, err=0, addr=BASE_ADDR, out_valid one cycle after accept.
- sd: opcode 0100011, rs1=3, rs2=2, funct3=3, imm=8 → 32'h0021B423.
- beq: opcode 1100011, rs1=rs2=0, imm=-4096 → 32'h80000063, err=0. Then imm=4096 → err=1, err_count=1.
- jal: opcode 1101111, rd=1, imm=2048 → 32'h001000EF. Then imm=3 → err=1.
- lui: opcode 0110111, rd=5, imm=0x12345000 → 32'h123452B7. Then imm=0x12345001 → err=1.
- Backpressure/reset, with out_ready=0 and 3 words offered:
  - in_ready drops after 2 accepts and the third is held.
  - Raising out_ready yields addrs BASE_ADDR, +4, +8 in order.
  - Asserting reset with 2 words buffered → out_valid=0 next cycle, and the next word's addr is BASE_ADDR.
- Random: every legal encoding, decoded by the core's immediate decode, returns the original imm.
